// File: rtl/npu_win_pkg.sv
// Shared encodings and helpers for the multi-channel window buffer.
// Mode, FSM state and flat-window offset used by window_buf_mc.
package npu_win_pkg;

    localparam logic WIN_MODE_FULL  = 1'b0;
    localparam logic WIN_MODE_SLIDE = 1'b1;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } win_state_e;

    function automatic int win_bit_off(
        input int elem_w,
        input int k,
        input int c,
        input int idx
    );
        return (c * k * k + idx) * elem_w;
    endfunction

endpackage

// File: rtl/win_plane.sv
// One K x K plane of window elements for a single channel.
// Supports raster writes, row shift-left with right-column load, and clear.
module win_plane
    import npu_win_pkg::*;
#(
    parameter int ELEM_W = 8,
    parameter int K      = 3,
    parameter int ADDR_W = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    input  logic                   i_we,
    input  logic                   i_shift,
    input  logic [ADDR_W-1:0]      i_idx,
    input  logic [ELEM_W-1:0]      i_data,
    output logic [K*K*ELEM_W-1:0]  o_plane
);

    logic [ELEM_W-1:0] elem_q [K*K];
    logic [ELEM_W-1:0] elem_d [K*K];

    always_comb begin
        elem_d = elem_q;
        if (i_clear) begin
            for (int i = 0; i < K*K; i++) begin
                elem_d[i] = '0;
            end
        end else if (i_we && i_shift) begin
            // i_idx selects the row being slid
            for (int r = 0; r < K; r++) begin
                if (int'(i_idx) == r) begin
                    for (int col = 0; col < K-1; col++) begin
                        elem_d[r*K+col] = elem_q[r*K+col+1];
                    end
                    elem_d[r*K+K-1] = i_data;
                end
            end
        end else if (i_we) begin
            for (int i = 0; i < K*K; i++) begin
                if (int'(i_idx) == i) begin
                    elem_d[i] = i_data;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < K*K; i++) begin
                elem_q[i] <= '0;
            end
        end else begin
            elem_q <= elem_d;
        end
    end

    for (genvar i = 0; i < K*K; i++) begin : g_out
        assign o_plane[win_bit_off(ELEM_W, K, 0, i) +: ELEM_W] = elem_q[i];
    end

endmodule

// File: rtl/window_buf_mc.sv
// Multi-channel K x K convolution window buffer with FULL/SLIDE loading,
// valid/ready in and out, and a combinational random-read port.
module window_buf_mc
    import npu_win_pkg::*;
#(
    parameter  int ELEM_W = 8,
    parameter  int K      = 3,
    parameter  int CH     = 2,
    localparam int ADDR_W = (K*K > 1) ? $clog2(K*K) : 1,
    localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clear,
    input  logic                      i_mode,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CH*ELEM_W-1:0]      s_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [CH*K*K*ELEM_W-1:0]  o_window,
    output logic                      o_primed,
    input  logic [CH_W-1:0]           i_rd_ch,
    input  logic [ADDR_W-1:0]         i_rd_addr,
    output logic [ELEM_W-1:0]         o_rd_data
);

    win_state_e        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              mode_q, mode_d;
    logic              primed_q, primed_d;

    logic accept;
    logic eff_mode;
    logic last_beat;

    assign accept   = s_valid && s_ready && !i_clear;
    // A SLIDE is only meaningful once a full window has been loaded
    assign eff_mode = (cnt_q == '0) ? (i_mode & primed_q) : mode_q;
    assign last_beat = (eff_mode == WIN_MODE_SLIDE) ?
                       (cnt_q == ADDR_W'(K-1)) :
                       (cnt_q == ADDR_W'(K*K-1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        primed_d = primed_q;
        s_ready  = (state_q == ST_FILL);
        m_valid  = (state_q == ST_HOLD);
        if (i_clear) begin
            state_d  = ST_FILL;
            cnt_d    = '0;
            mode_d   = WIN_MODE_FULL;
            primed_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_FILL: begin
                    if (accept) begin
                        mode_d = eff_mode;
                        if (last_beat) begin
                            cnt_d   = '0;
                            state_d = ST_HOLD;
                            if (eff_mode == WIN_MODE_FULL) begin
                                primed_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + ADDR_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (m_ready) begin
                        state_d = ST_FILL;
                    end
                end
                default: state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_FILL;
            cnt_q    <= '0;
            mode_q   <= WIN_MODE_FULL;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mode_q   <= mode_d;
            primed_q <= primed_d;
        end
    end

    assign o_primed = primed_q;

    for (genvar c = 0; c < CH; c++) begin : g_plane
        win_plane #(
            .ELEM_W (ELEM_W),
            .K      (K),
            .ADDR_W (ADDR_W)
        ) u_plane (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_clear (i_clear),
            .i_we    (accept),
            .i_shift (eff_mode),
            .i_idx   (cnt_q),
            .i_data  (s_data[c*ELEM_W +: ELEM_W]),
            .o_plane (o_window[c*K*K*ELEM_W +: K*K*ELEM_W])
        );
    end

    // Out-of-range channel or index falls through to zero
    always_comb begin
        o_rd_data = '0;
        for (int c = 0; c < CH; c++) begin
            for (int i = 0; i < K*K; i++) begin
                if (int'(i_rd_ch) == c && int'(i_rd_addr) == i) begin
                    o_rd_data = o_window[win_bit_off(ELEM_W, K, c, i) +: ELEM_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_window_buf_mc.sv
// Self-checking bench for window_buf_mc (K=3, CH=2, ELEM_W=8)
// against a behavioural window model.
module tb_window_buf_mc;

    logic         i_clk = 1'b0;
    logic         i_rst_n;
    logic         i_clear;
    logic         i_mode;
    logic         s_valid;
    logic         s_ready;
    logic [15:0]  s_data;
    logic         m_valid;
    logic         m_ready;
    logic [143:0] o_window;
    logic         o_primed;
    logic         i_rd_ch;
    logic [3:0]   i_rd_addr;
    logic [7:0]   o_rd_data;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mdl [2][9];
    int         m_cnt;
    bit         m_slide;
    bit         m_primed;
    bit         m_hold;

    window_buf_mc dut (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (i_clear),
        .i_mode    (i_mode),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .o_window  (o_window),
        .o_primed  (o_primed),
        .i_rd_ch   (i_rd_ch),
        .i_rd_addr (i_rd_addr),
        .o_rd_data (o_rd_data)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [143:0] obs,
                       input logic [143:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic mdl_reset();
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 9; i++) mdl[c][i] = 8'h00;
        m_cnt = 0;
        m_slide = 0;
        m_primed = 0;
        m_hold = 0;
    endtask

    function automatic logic [143:0] mdl_flat();
        logic [143:0] f;
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 9; i++) f[(c*9+i)*8 +: 8] = mdl[c][i];
        return f;
    endfunction

    task automatic mdl_beat(input logic [15:0] d, input logic md);
        if (m_cnt == 0) m_slide = md && m_primed;
        if (!m_slide) begin
            for (int c = 0; c < 2; c++) mdl[c][m_cnt] = d[c*8 +: 8];
            m_cnt++;
            if (m_cnt == 9) begin
                m_cnt = 0;
                m_hold = 1;
                m_primed = 1;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                for (int col = 0; col < 2; col++)
                    mdl[c][m_cnt*3+col] = mdl[c][m_cnt*3+col+1];
                mdl[c][m_cnt*3+2] = d[c*8 +: 8];
            end
            m_cnt++;
            if (m_cnt == 3) begin
                m_cnt = 0;
                m_hold = 1;
            end
        end
    endtask

    task automatic send(input logic [15:0] d, input logic md, input bit gaps);
        int n;
        if (gaps && $urandom_range(0, 1) == 1) begin
            s_valid = 1'b0;
            step();
        end
        s_valid = 1'b1;
        s_data  = d;
        i_mode  = md;
        n = 0;
        while (!s_ready && n < 20) begin
            step();
            n++;
        end
        chk("beat_ready", s_ready, 1'b1);
        step();
        mdl_beat(d, md);
        s_valid = 1'b0;
    endtask

    task automatic handshake();
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        m_hold = 0;
        chk("hs_mvalid", m_valid, 1'b0);
        chk("hs_sready", s_ready, 1'b1);
    endtask

    task automatic rd(input logic ch, input logic [3:0] a,
                      input logic [7:0] exp, input string tag);
        i_rd_ch   = ch;
        i_rd_addr = a;
        #1;
        chk(tag, o_rd_data, exp);
    endtask

    logic [7:0]  exp_ch0 [9];
    logic [15:0] rdat;

    initial begin
        i_rst_n = 1'b0;
        i_clear = 1'b0;
        i_mode  = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        i_rd_ch = 1'b0;
        i_rd_addr = '0;
        mdl_reset();
        #12;
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_sready", s_ready, 1'b1);
        chk("rst_primed", o_primed, 1'b0);
        chk("rst_window", o_window, 144'h0);
        i_rst_n = 1'b1;
        step();

        // FULL load with patterned data
        for (int n = 0; n < 9; n++) begin
            send({8'h80 + 8'(n), 8'(n)}, 1'b0, 1'b0);
            chk("full_mvalid", m_valid, m_hold);
        end
        chk("full_mvalid1", m_valid, 1'b1);
        chk("full_sready0", s_ready, 1'b0);
        chk("full_primed", o_primed, 1'b1);
        chk("full_win", o_window, mdl_flat());
        rd(1'b0, 4'd4, 8'h04, "rd_ch0_4");
        rd(1'b1, 4'd8, 8'h88, "rd_ch1_8");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_win", o_window, mdl_flat());
            chk("hold_mvalid", m_valid, 1'b1);
        end
        handshake();
        chk("post_hs_win", o_window, mdl_flat());

        // SLIDE three columns
        for (int r = 0; r < 3; r++) begin
            chk("slide_mvalid_pre", m_valid, 1'b0);
            send({8'hB0 + 8'(r), 8'hA0 + 8'(r)}, 1'b1, 1'b0);
        end
        chk("slide_mvalid", m_valid, 1'b1);
        chk("slide_win", o_window, mdl_flat());
        exp_ch0 = '{8'h01, 8'h02, 8'hA0, 8'h04, 8'h05, 8'hA1,
                    8'h07, 8'h08, 8'hA2};
        for (int i = 0; i < 9; i++) rd(1'b0, 4'(i), exp_ch0[i], "slide_ch0");
        rd(1'b0, 4'd9, 8'h00, "rd_oob9");
        rd(1'b1, 4'd15, 8'h00, "rd_oob15");

        // Asynchronous reset while holding a window
        step();
        #3;
        i_rst_n = 1'b0;
        #1;
        chk("arst_mvalid", m_valid, 1'b0);
        chk("arst_primed", o_primed, 1'b0);
        chk("arst_win", o_window, 144'h0);
        mdl_reset();
        #2;
        i_rst_n = 1'b1;
        step();

        // SLIDE requested while unprimed behaves as FULL
        for (int n = 0; n < 9; n++) begin
            rdat = 16'($urandom);
            send(rdat, 1'b1, 1'b0);
            chk("unp_mvalid", m_valid, m_hold);
            chk("unp_primed", o_primed, m_primed);
        end
        chk("unp_win", o_window, mdl_flat());
        handshake();

        // Gappy FULL load, mode toggled after the first beat
        for (int n = 0; n < 9; n++) begin
            rdat = 16'($urandom);
            send(rdat, (n == 0) ? 1'b0 : 1'b1, 1'b1);
            chk("gap_mvalid", m_valid, m_hold);
        end
        chk("gap_win", o_window, mdl_flat());
        handshake();

        // Clear mid-window with a colliding beat
        for (int n = 0; n < 6; n++) send(16'($urandom), 1'b0, 1'b0);
        s_valid = 1'b1;
        s_data  = 16'hFFFF;
        i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        s_valid = 1'b0;
        mdl_reset();
        chk("clr_primed", o_primed, 1'b0);
        chk("clr_mvalid", m_valid, 1'b0);
        chk("clr_sready", s_ready, 1'b1);
        for (int c = 0; c < 2; c++)
            for (int i = 0; i < 9; i++) rd(1'(c), 4'(i), 8'h00, "clr_rd");
        for (int n = 0; n < 9; n++) begin
            send(16'($urandom), 1'b0, 1'b0);
            chk("fresh_mvalid", m_valid, m_hold);
        end
        chk("fresh_win", o_window, mdl_flat());
        chk("fresh_primed", o_primed, 1'b1);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
